// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and related logic.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  // True for opcodes whose rs2 field is a real source register.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX feeding a source of the
// instruction in decode.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [31:0] if_id_ir,
  input  logic [31:0] id_ex_ir,
  output logic        load_use
);

  logic [6:0] ex_op;
  logic [6:0] id_op;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       unused_bits;

  assign ex_op  = id_ex_ir[OPC_MSB:OPC_LSB];
  assign ex_rd  = id_ex_ir[RD_MSB:RD_LSB];
  assign id_op  = if_id_ir[OPC_MSB:OPC_LSB];
  assign id_rs1 = if_id_ir[RS1_MSB:RS1_LSB];
  assign id_rs2 = if_id_ir[RS2_MSB:RS2_LSB];

  assign unused_bits = ^{if_id_ir[14:7], if_id_ir[31:25], id_ex_ir[31:12]};

  // Load destination matches rs1, or rs2 when the decode opcode reads rs2.
  always_comb begin
    load_use = 1'b0;
    if ((ex_op == OP_LOAD) && (ex_rd != '0)) begin
      load_use = (ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2(id_op));
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, taken-branch flushes and
// load-use bubbles, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_ir,
  input  logic [31:0]      id_ex_ir,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             back_stall,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FC_LOAD   = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       pend_q, pend_d;
  logic       load_use;
  logic       mem_wait;
  logic       pc_stall_c, if_id_stall_c, id_ex_bubble_c, if_id_flush_c, back_stall_c;

  hazard_detect u_hazard_detect (
    .if_id_ir (if_id_ir),
    .id_ex_ir (id_ex_ir),
    .load_use (load_use)
  );

  assign mem_wait = dmem_req & ~dmem_ready;

  // State, flush counter and pending-flush flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and control outputs; priority is memory wait, branch, load-use.
  // fcnt counts FLUSH-state cycles still to run, so the RUN-state branch cycle
  // loads FLUSH_CYCLES-1 while a flush deferred past MEM_WAIT loads FLUSH_CYCLES.
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    pend_d         = pend_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;
    back_stall_c   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          back_stall_c  = 1'b1;
          pend_d        = br_taken;
          state_d       = MEM_WAIT;
        end else if (br_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          fcnt_d         = FC_RELOAD;
          if (FC_RELOAD != 3'd0) state_d = FLUSH;
        end else if (load_use) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          back_stall_c  = 1'b1;
          if (br_taken) pend_d = 1'b1;
        end else if (pend_q || br_taken) begin
          state_d = FLUSH;
          fcnt_d  = FC_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
        if (br_taken) begin
          fcnt_d = FC_RELOAD;
          if (FC_RELOAD == 3'd0) state_d = RUN;
        end else if (fcnt_q <= 3'd1) begin
          fcnt_d  = '0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign pc_stall     = rst_n & pc_stall_c;
  assign if_id_stall  = rst_n & if_id_stall_c;
  assign id_ex_bubble = rst_n & id_ex_bubble_c;
  assign if_id_flush  = rst_n & if_id_flush_c;
  assign back_stall   = rst_n & back_stall_c;
  assign state_o      = state_q;

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of bubble cycles injected after a taken branch (range 1-7).
REQ-002 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port if_id_ir, input, 32, instruction in decode.
REQ-006 SHALL have port id_ex_ir, input, 32, instruction in execute.
REQ-007 SHALL have port br_taken, input, 1, branch or jump resolved taken in EX this cycle.
REQ-008 SHALL have port dmem_req, input, 1, MEM-stage data-memory access pending.
REQ-009 SHALL have port dmem_ready, input, 1, data memory completes the access this cycle.
REQ-010 SHALL have port pc_stall, output, 1, hold the PC.
REQ-011 SHALL have port if_id_stall, output, 1, hold the IF/ID register.
REQ-012 SHALL have port id_ex_bubble, output, 1, load NOP into ID/EX.
REQ-013 SHALL have port if_id_flush, output, 1, load NOP into IF/ID.
REQ-014 SHALL have port back_stall, output, 1, hold ID/EX, EX/MEM and MEM/WB.
REQ-015 SHALL have port state_o, output, 2, current FSM state.
REQ-016 SHALL have port stall_cnt, output, CNT_W, cycles with pc_stall high; saturating.
REQ-017 SHALL have port flush_cnt, output, CNT_W, cycles with if_id_flush high; saturating.

Function
REQ-018 SHALL implement the FSM states RUN, MEM_WAIT and FLUSH.
REQ-019 Load-use detect SHALL be true when all of the following hold: id_ex_ir[6:0] equals 7'b0000011; rd equals id_ex_ir[11:7] and rd is nonzero; rd equals if_id_ir[19:15], or rd equals if_id_ir[24:20] and the if_id opcode is R-type (0110011), store (0100011) or branch (1100011).
REQ-020 In RUN with dmem_req high and dmem_ready low, the next state SHALL be MEM_WAIT; pc_stall, if_id_stall and back_stall SHALL be high in that same cycle.
REQ-021 In MEM_WAIT, pc_stall, if_id_stall and back_stall SHALL stay high until the cycle dmem_ready is high; that cycle SHALL deassert all three.
REQ-022 When MEM_WAIT ends, the next state SHALL be FLUSH if a flush is pending, otherwise RUN.
REQ-023 In RUN with br_taken high and no memory wait, the block SHALL assert if_id_flush and id_ex_bubble that cycle, load the counter with FLUSH_CYCLES-1 and enter FLUSH; with FLUSH_CYCLES=1 it SHALL stay in RUN.
REQ-024 In FLUSH, if_id_flush and id_ex_bubble SHALL be high; the counter SHALL decrement each cycle, and the block SHALL return to RUN in the cycle after the counter reads 0.
REQ-025 br_taken arriving together with a memory wait SHALL set the 1-bit flush_pending flag; the flush SHALL execute on leaving MEM_WAIT, and the flag SHALL clear on entry to FLUSH.
REQ-026 A load-use detect in RUN with no memory wait and no branch SHALL assert pc_stall, if_id_stall and id_ex_bubble for exactly that cycle; the state SHALL remain RUN.
REQ-027 Priority SHALL be memory wait, then branch flush, then load-use; a load-use detect during FLUSH SHALL be ignored.
REQ-028 br_taken during FLUSH SHALL reload the counter with FLUSH_CYCLES-1.
REQ-029 Counters SHALL increment by 1 per qualifying cycle and hold at all-ones.
REQ-030 All stall/flush outputs SHALL be combinational from state and inputs; state, flag and counters SHALL be registered.

Reset
REQ-031 On rst_n low, asynchronously: state RUN, flush counter 0, flush_pending 0, stall_cnt 0, flush_cnt 0.
REQ-032 During reset all stall/flush outputs SHALL be 0 regardless of inputs.
REQ-033 On reset deassertion, the first edge SHALL evaluate from RUN.
REQ-034 Reset asserted in MEM_WAIT or FLUSH SHALL discard the pending operation.

Structure
REQ-035 The shared package SHALL hold: the state enum (RUN=0, MEM_WAIT=1, FLUSH=2); opcode constants OP_LOAD, OP_STORE, OP_BRANCH and OP_RTYPE; and the register-field bit-position constants.
REQ-036 SHALL instantiate one sub-module, hazard_detect (combinational load-use detect), reusable by the forwarding logic.

Verification
REQ-037 Bench SHALL cover load-use: id_ex_ir=lw x5,0(x1), if_id_ir=add x6,x5,x2 -> one cycle of pc_stall/if_id_stall/id_ex_bubble high, stall_cnt=1; with rd=x0 -> no stall.
REQ-038 Bench SHALL cover memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> back_stall high 3 cycles, then low; state_o 1 then 0.
REQ-039 Bench SHALL cover branch flush: br_taken pulse, FLUSH_CYCLES=2 -> if_id_flush high 2 cycles, flush_cnt=2, state_o returns to 0.
REQ-040 Bench SHALL cover branch during wait: br_taken during MEM_WAIT -> flush starts in the cycle after dmem_ready, lasting FLUSH_CYCLES cycles.
REQ-041 Bench SHALL cover reset mid-FLUSH: rst_n low for 1 cycle -> all outputs 0, state_o=0, counters 0.
REQ-042 Bench SHALL cover saturation: force stall_cnt to all-ones, then a stall -> value unchanged.
